// File: rtl/mem_pkg.sv
// Shared types and constants for the block memory responder.
package mem_pkg;

   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned BLOCK_WORDS = 4;
   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned NUM_BLOCKS  = 64;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   typedef struct packed {
      logic         write;
      logic [5:0]   block;
      logic [127:0] wdata;
   } req_t;

   // Power-up image of one block: word w of the whole array holds the value w.
   function automatic logic [BLOCK_W-1:0] block_init(input logic [5:0] blk);
      logic [BLOCK_W-1:0] data;
      data = '0;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
         data[w*WORD_W +: WORD_W] = WORD_W'({blk, 2'(w)});
      end
      return data;
   endfunction

endpackage

// File: rtl/block_mem_array.sv
// 64 x 128-bit backing store: one block-wide port, synchronous write, read data
// presented for the caller to register on its access edge. No reset, so
// committed writes survive a reset of the controller.
module block_mem_array
   import mem_pkg::*;
(
   input  logic               clk,
   input  logic               we,
   input  logic [5:0]         addr,
   input  logic [BLOCK_W-1:0] wdata,
   output logic [BLOCK_W-1:0] rdata
);

   logic [BLOCK_W-1:0] rows [NUM_BLOCKS];

   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_row
      // Declaration value is the power-up content of this block.
      logic [BLOCK_W-1:0] row_q = block_init(6'(g));

      // Commit a full block write when addressed.
      always_ff @(posedge clk) begin
         if (we && (addr == 6'(g))) begin
            row_q <= wdata;
         end
      end

      assign rows[g] = row_q;
   end

   assign rdata = rows[addr];

endmodule

// File: rtl/block_mem_responder.sv
// Main-memory responder for cache refill/write-back: accepts one block request,
// services it after LATENCY cycles, and holds the response until accepted.
module block_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [BLOCK_W-1:0] req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_write,
   output logic [BLOCK_W-1:0] resp_rdata
);

   state_e             state_q, state_d;
   logic               live_q;
   logic [3:0]         cnt_q;
   req_t               req_q;
   logic               resp_write_q;
   logic [BLOCK_W-1:0] resp_rdata_q;
   logic [BLOCK_W-1:0] arr_rdata;
   logic               accept, access, resp_fire;

   // Byte offset within a block carries no information here.
   logic               unused_offset;
   assign unused_offset = ^req_addr[3:0];

   assign accept    = req_valid && req_ready;
   assign access    = (state_q == BUSY) && (cnt_q == 4'd0);
   assign resp_fire = resp_valid && resp_ready;

   block_mem_array u_array (
      .clk   (clk),
      .we    (access && req_q.write),
      .addr  (req_q.block),
      .wdata (req_q.wdata),
      .rdata (arr_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = BUSY;
         BUSY:    if (access)    state_d = RESP;
         RESP:    if (resp_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; live_q keeps req_ready low until the first edge after reset.
   always_comb begin
      req_ready  = (state_q == IDLE) && live_q;
      resp_valid = (state_q == RESP);
   end

   // Request capture, latency counter and held response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q       <= 1'b0;
         cnt_q        <= 4'd0;
         req_q        <= '0;
         resp_write_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         live_q <= 1'b1;
         if (accept) begin
            req_q <= '{write: req_write, block: req_addr[9:4], wdata: req_wdata};
            cnt_q <= 4'(LATENCY - 1);
         end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (access) begin
            resp_write_q <= req_q.write;
            resp_rdata_q <= req_q.write ? '0 : arr_rdata;
         end
      end
   end

   assign resp_write = resp_write_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench: one responder at LATENCY=4 and one at LATENCY=1 with resp_ready tied high.
module tb_block_mem_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;

   // Instance A (LATENCY = 4).
   logic         req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write;
   logic [9:0]   req_addr;
   logic [127:0] req_wdata, resp_rdata;

   // Instance B (LATENCY = 1).
   logic         req_valid_b, req_ready_b, resp_valid_b, resp_write_b;
   logic [9:0]   req_addr_b;
   logic [127:0] resp_rdata_b;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   block_mem_responder #(.LATENCY(4)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_write (resp_write),
      .resp_rdata (resp_rdata)
   );

   block_mem_responder #(.LATENCY(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_b),
      .req_ready  (req_ready_b),
      .req_write  (1'b0),
      .req_addr   (req_addr_b),
      .req_wdata  ('0),
      .resp_valid (resp_valid_b),
      .resp_ready (1'b1),
      .resp_write (resp_write_b),
      .resp_rdata (resp_rdata_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request on A for exactly one edge (caller ensures req_ready=1).
   task automatic issue(input logic w, input logic [9:0] a, input logic [127:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      tick();
      req_valid = 1'b0;
   endtask

   // Count edges after accept until resp_valid; bounded.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   task automatic ack(input string tag);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_valid_drop"}, 128'(resp_valid), 128'd0);
      check({tag, "_ready_back"}, 128'(req_ready), 128'd1);
   endtask

   localparam logic [127:0] BLK1  = 128'h00000007_00000006_00000005_00000004;
   localparam logic [127:0] BLK2  = 128'h0000000B_0000000A_00000009_00000008;
   localparam logic [127:0] BLK0  = 128'h00000003_00000002_00000001_00000000;
   localparam logic [127:0] BLK5  = 128'h00000017_00000016_00000015_00000014;
   localparam logic [127:0] BLK63 = 128'h000000FF_000000FE_000000FD_000000FC;
   localparam logic [127:0] WD    = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] WE0   = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;

   initial begin
      int lat;
      int acc [2];
      int rsp [2];
      logic [127:0] rd [2];
      int na, nr;

      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      req_valid_b = 1'b0; req_addr_b = '0;

      // Reset values while held.
      tick(); tick();
      check("rst_req_ready", 128'(req_ready), 128'd0);
      check("rst_resp_valid", 128'(resp_valid), 128'd0);
      check("rst_resp_write", 128'(resp_write), 128'd0);
      check("rst_resp_rdata", resp_rdata, 128'd0);
      rst_n = 1'b1;
      tick();
      check("ready_after_first_edge", 128'(req_ready), 128'd1);
      check("ready_b_after_first_edge", 128'(req_ready_b), 128'd1);

      // Read block 1.
      issue(1'b0, 10'h010, '0);
      check("busy_ready_low", 128'(req_ready), 128'd0);
      wait_resp(lat);
      check("read1_latency", 128'(lat), 128'd4);
      check("read1_rdata", resp_rdata, BLK1);
      check("read1_write", 128'(resp_write), 128'd0);
      ack("read1");

      // Write block 63 via unaligned address, then read back.
      issue(1'b1, 10'h3F5, WD);
      wait_resp(lat);
      check("wr63_latency", 128'(lat), 128'd4);
      check("wr63_write", 128'(resp_write), 128'd1);
      check("wr63_rdata_zero", resp_rdata, 128'd0);
      ack("wr63");
      issue(1'b0, 10'h3F0, '0);
      wait_resp(lat);
      check("rd63_rdata", resp_rdata, WD);
      check("rd63_write", 128'(resp_write), 128'd0);
      ack("rd63");

      // Stall in RESP while req_* churns.
      issue(1'b0, 10'h020, '0);
      wait_resp(lat);
      for (int i = 0; i < 10; i++) begin
         req_valid = i[0];
         req_write = 1'b1;
         req_addr  = 10'h000;
         req_wdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
         check("hold_valid", 128'(resp_valid), 128'd1);
         check("hold_rdata", resp_rdata, BLK2);
         check("hold_ready", 128'(req_ready), 128'd0);
      end
      req_valid = 1'b0;
      ack("hold");
      repeat (6) tick();
      check("hold_no_extra_req", 128'(resp_valid), 128'd0);
      issue(1'b0, 10'h000, '0);
      wait_resp(lat);
      check("hold_block0_untouched", resp_rdata, BLK0);
      ack("rd0");

      // Reset two cycles after accepting a write to block 5.
      issue(1'b1, 10'h050, WD);
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 128'(req_ready), 128'd0);
      check("midrst_rdata", resp_rdata, 128'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("midrst_ready_back", 128'(req_ready), 128'd1);
      issue(1'b0, 10'h050, '0);
      wait_resp(lat);
      check("midrst_lat", 128'(lat), 128'd4);
      check("midrst_write_dropped", resp_rdata, BLK5);
      ack("rd5");

      // Write block 0 then read it straight away.
      issue(1'b1, 10'h00C, WE0);
      wait_resp(lat);
      check("wr0_write", 128'(resp_write), 128'd1);
      ack("wr0");
      issue(1'b0, 10'h000, '0);
      wait_resp(lat);
      check("rd0_after_write", resp_rdata, WE0);
      ack("rd0b");

      // LATENCY=1 back-to-back reads with resp_ready tied high.
      acc = '{-100, -100};
      rsp = '{-1000, -1000};
      rd  = '{'0, '0};
      na = 0;
      nr = 0;
      req_valid_b = 1'b1;
      req_addr_b  = 10'h3F0;
      for (int i = 0; i < 20 && nr < 2; i++) begin
         if (req_valid_b && req_ready_b && na < 2) begin
            acc[na] = cyc + 1;
            na++;
         end
         tick();
         if (na == 1) req_addr_b = 10'h010;
         if (na == 2) req_valid_b = 1'b0;
         if (resp_valid_b && nr < 2) begin
            rsp[nr] = cyc;
            rd[nr]  = resp_rdata_b;
            nr++;
         end
      end
      req_valid_b = 1'b0;
      check("l1_accept_spacing", 128'(acc[1] - acc[0]), 128'd3);
      check("l1_resp0_latency", 128'(rsp[0] - acc[0]), 128'd1);
      check("l1_resp1_latency", 128'(rsp[1] - acc[1]), 128'd1);
      check("l1_rd63", rd[0], BLK63);
      check("l1_rd1", rd[1], BLK1);
      check("l1_write_flag", 128'(resp_write_b), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Main-memory responder on the cache refill/write-back interface. It accepts one 128-bit block read or block write request at a time from the data cache over a valid/ready handshake. It services the request after a fixed access latency and returns a held response, write-ack or read data, that the cache must accept. It sits directly below the cache and owns the 1 KiB backing store, organised as 64 blocks of 4 words of 32 bits.

## Interface
- LATENCY, 4: cycles from request accept to response valid; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = block write (write-back), 0 = block read (refill).
- req_addr  in  10  byte address; block number = req_addr[9:4]; bits [3:0] ignored.
- req_wdata  in  128  write block; word 0 in [31:0], word 3 in [127:96].
- resp_valid  out  1  response present.
- resp_ready  in  1  cache accepts response.
- resp_write  out  1  echoes req_write of the request being answered.
- resp_rdata  out  128  read block, same word order as req_wdata; all-zero for write acks.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture write, block number and wdata; load the counter with LATENCY-1; go to BUSY.
- BUSY: req_ready=0 and resp_valid=0. Decrement the counter each cycle. When the counter is 0, perform the access on that edge and go to RESP.
  - Write: store all 4 words to the block.
  - Read: latch the 4 words of the block into resp_rdata.
- RESP: resp_valid=1 and req_ready=0. resp_rdata and resp_write are held stable until resp_valid&&resp_ready. On that edge go to IDLE.
- Only one request is ever outstanding. The captured request is immune to req_* changes after accept.
- The array has no reset. Its simulation initial content is word w (w = 0..255) = 32'h0000_0000 + w.
- Reset while asserted: state=IDLE, req_ready=0, resp_valid=0, resp_write=0, resp_rdata=0, counter=0. req_ready rises on the first clock edge after rst_n deasserts.
- Reset mid-operation: any request in BUSY is dropped. A write not yet committed never reaches the array. A pending RESP is lost. The array keeps all previously committed writes.
- A read after a write to the same block returns the newly written data, because commit precedes the next accept.

## Timing
- Accept at edge k, then resp_valid=1 after edge k+LATENCY. The access happens at edge k+LATENCY.
- LATENCY=1 is legal: BUSY lasts one cycle.
- Response handshake at edge m: resp_valid=0 and req_ready=1 after edge m. There is no same-cycle accept of a new request; the minimum request-to-request spacing is LATENCY+2 cycles.
- resp_ready held low keeps RESP indefinitely, with no timeout.
- resp_ready while resp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; it is not queued.
- Counter width is 4 bits. The counter decrements from LATENCY-1 to 0 and never wraps.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W=10, WORD_W=32, BLOCK_WORDS=4, BLOCK_W=128, NUM_BLOCKS=64.
  - The FSM state enum (IDLE, BUSY, RESP).
  - A request struct {write, block[5:0], wdata[127:0]}.
- One sub-module, block_mem_array: 64x128 storage with one synchronous block-wide read/write port and the initial-content load. The top level holds the FSM, counter, request capture and response registers.

## Test plan
- Reset, then read at req_addr=10'h010 -> req_ready=1 after the first edge; resp_valid after exactly 4 edges from accept; resp_rdata=128'h00000007_00000006_00000005_00000004.
- Write req_addr=10'h3F5 with wdata=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, then read 10'h3F0 -> write ack with resp_write=1 and rdata=0; the read returns the same 128-bit value (bits [3:0] ignored).
- Hold resp_ready=0 for 10 cycles in RESP while toggling req_valid and req_wdata -> resp_valid and rdata remain stable, req_ready=0, and no extra request is captured.
- Assert rst_n=0 two cycles after accepting a write to block 5 (LATENCY=4), release, then read block 5 -> initial content 0x14..0x17 is returned; the write was dropped.
- LATENCY=1: back-to-back read requests with resp_ready tied high -> responses one cycle after each accept; the second accept occurs 3 cycles after the first (LATENCY+2 spacing).
- Write block 0 and then immediately read block 0, plus read block 63 -> block 0 returns the written data; block 63 returns words 0xFC..0xFF.
